conv_window_gen: RTL and testbench

//  Upstream feeder for the serial 3x3 convolution engine. Accepts a raster pixel stream and

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_linebuf.sv | 30 +++
 rtl/conv_window_gen.sv | 168 ++++++++++++++++
 tb/tb_conv_window_gen.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution window generator.
package conv_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned IMG_W_DEF      = 8;
  localparam int unsigned IMG_H_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_linebuf.sv
// Two-row line buffer with one shared column address.
// Reads are combinational; a write shifts row 0 into row 1 at that column.
module conv_linebuf
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_W      = IMG_W_DEF
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [cnt_w(IMG_W)-1:0]      i_addr,
  input  logic signed [DATA_WIDTH-1:0] i_din,
  output logic signed [DATA_WIDTH-1:0] o_lb0,
  output logic signed [DATA_WIDTH-1:0] o_lb1
);

  logic signed [DATA_WIDTH-1:0] r_lb0 [IMG_W];
  logic signed [DATA_WIDTH-1:0] r_lb1 [IMG_W];

  assign o_lb0 = r_lb0[i_addr];
  assign o_lb1 = r_lb1[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_lb1[i_addr] <= r_lb0[i_addr];
      r_lb0[i_addr] <= i_din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster stream to 3x3 window feeder with handshake to the serial conv engine.
// Optional macro CONV_WIN_COORD_EN adds win_row/win_col output-map coordinates.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] pix_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  output logic signed [DATA_WIDTH-1:0] a0,
  output logic signed [DATA_WIDTH-1:0] a1,
  output logic signed [DATA_WIDTH-1:0] a2,
  output logic signed [DATA_WIDTH-1:0] a3,
  output logic signed [DATA_WIDTH-1:0] a4,
  output logic signed [DATA_WIDTH-1:0] a5,
  output logic signed [DATA_WIDTH-1:0] a6,
  output logic signed [DATA_WIDTH-1:0] a7,
  output logic signed [DATA_WIDTH-1:0] a8,
  output logic                         conv_start,
  input  logic                         conv_done,
  output logic                         frame_done
`ifdef CONV_WIN_COORD_EN
  ,
  output logic [cnt_w(IMG_H)-1:0]      win_row,
  output logic [cnt_w(IMG_W)-1:0]      win_col
`endif
);

  localparam int unsigned ROW_W = cnt_w(IMG_H);
  localparam int unsigned COL_W = cnt_w(IMG_W);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

  state_t                       r_state;
  logic [ROW_W-1:0]             r_row;
  logic [COL_W-1:0]             r_col;
  logic signed [DATA_WIDTH-1:0] r_win [9];
  logic                         r_pix_ready;
  logic                         r_conv_start;
  logic                         r_frame_done;
  logic                         r_last;
`ifdef CONV_WIN_COORD_EN
  logic [ROW_W-1:0]             r_win_row;
  logic [COL_W-1:0]             r_win_col;
`endif

  logic                         w_xfer;
  logic                         w_col_last;
  logic                         w_row_last;
  logic                         w_issue;
  logic signed [DATA_WIDTH-1:0] w_lb0;
  logic signed [DATA_WIDTH-1:0] w_lb1;

  // clr drops a pixel presented in the same cycle so the new frame starts clean.
  assign w_xfer     = r_pix_ready && pix_valid && !clr;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_issue    = (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  conv_linebuf #(
    .DATA_WIDTH(DATA_WIDTH),
    .IMG_W     (IMG_W)
  ) u_linebuf (
    .clk   (clk),
    .i_we  (w_xfer),
    .i_addr(r_col),
    .i_din (pix_in),
    .o_lb0 (w_lb0),
    .o_lb1 (w_lb1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_win        <= '{default: '0};
      r_pix_ready  <= 1'b0;
      r_conv_start <= 1'b0;
      r_frame_done <= 1'b0;
      r_last       <= 1'b0;
`ifdef CONV_WIN_COORD_EN
      r_win_row    <= '0;
      r_win_col    <= '0;
`endif
    end else if (clr) begin
      r_state      <= ST_ACCEPT;
      r_row        <= '0;
      r_col        <= '0;
      r_pix_ready  <= 1'b1;
      r_conv_start <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_conv_start <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_ACCEPT;
          r_pix_ready <= 1'b1;
        end
        ST_ACCEPT: begin
          if (w_xfer) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_lb1;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_lb0;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= pix_in;
            if (w_col_last) begin
              r_col <= '0;
              r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_issue) begin
              r_state      <= ST_START;
              r_pix_ready  <= 1'b0;
              r_conv_start <= 1'b1;
              r_last       <= w_row_last && w_col_last;
`ifdef CONV_WIN_COORD_EN
              r_win_row    <= r_row - ROW_TWO;
              r_win_col    <= r_col - COL_TWO;
`endif
            end
          end
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (conv_done) begin
            r_state      <= ST_ACCEPT;
            r_pix_ready  <= 1'b1;
            r_frame_done <= r_last;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pix_ready  = r_pix_ready;
  assign conv_start = r_conv_start;
  assign frame_done = r_frame_done;
  assign a0 = r_win[0];
  assign a1 = r_win[1];
  assign a2 = r_win[2];
  assign a3 = r_win[3];
  assign a4 = r_win[4];
  assign a5 = r_win[5];
  assign a6 = r_win[6];
  assign a7 = r_win[7];
  assign a8 = r_win[8];
`ifdef CONV_WIN_COORD_EN
  assign win_row = r_win_row;
  assign win_col = r_win_col;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized self-checking bench for conv_window_gen against an image-level window model.
module tb_conv_window_gen;

  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int TMO  = 400;

  typedef logic [9*DW-1:0] win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic pix_valid = 1'b0;
  logic conv_done = 1'b0;
  logic signed [DW-1:0] pix_in = '0;
  logic pix_ready, conv_start, frame_done;
  logic signed [DW-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
`ifdef CONV_WIN_COORD_EN
  logic [1:0] win_row, win_col;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_gen #(
    .DATA_WIDTH(DW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .a5(a5), .a6(a6), .a7(a7), .a8(a8),
    .conv_start(conv_start),
    .conv_done (conv_done),
    .frame_done(frame_done)
`ifdef CONV_WIN_COORD_EN
    ,
    .win_row   (win_row),
    .win_col   (win_col)
`endif
  );

  win_t w_cur;
  assign w_cur = {a0, a1, a2, a3, a4, a5, a6, a7, a8};

  // Reference image and expected windows derived directly from it.
  logic signed [DW-1:0] img [H][W];
  win_t exp_q[$];
  int   exp_coord_q[$];

  // Conv-engine stand-in and protocol observer.
  int   done_delay = 3;
  bit   rand_delay = 0;
  bit   pend = 0;
  int   cnt = 0;
  int   low_cnt = 0;
  win_t cap_win;
  win_t cap_q[$];
  int   coord_q[$];
  int   low_q[$];
  int   hold_err = 0, double_err = 0, fd_err = 0, ready_err = 0;
  int   fd_cnt = 0, done_total = 0, fd_done_idx = -1;
  bit   prev_start = 0, done_prev = 0, chk_ready = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      conv_done = 1'b0;
      if (!rst_n) begin
        pend = 0; prev_start = 0; done_prev = 0; chk_ready = 0;
        continue;
      end
      if (clr) begin
        pend = 0; chk_ready = 0;
      end
      if (chk_ready) begin
        chk_ready = 0;
        if (pix_ready !== 1'b1) ready_err++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_done_idx = done_total;
        if (!done_prev) fd_err++;
      end
      done_prev = 0;
      if (conv_start === 1'b1) begin
        if (prev_start || pend) double_err++;
        if (rand_delay) done_delay = int'($urandom_range(1, 6));
        pend = 1; cnt = 0;
        low_cnt = (pix_ready === 1'b0) ? 1 : 0;
        cap_win = w_cur;
        cap_q.push_back(w_cur);
`ifdef CONV_WIN_COORD_EN
        coord_q.push_back(int'(win_row) * 16 + int'(win_col));
`endif
      end else if (pend) begin
        cnt++;
        if (w_cur !== cap_win) hold_err++;
        if (pix_ready === 1'b0) low_cnt++;
        if (cnt == done_delay) begin
          conv_done = 1'b1;
          pend = 0; done_prev = 1; chk_ready = 1;
          done_total++;
          low_q.push_back(low_cnt);
        end
      end
      prev_start = (conv_start === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void fill_seq(input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = DW'(base + r * W + c);
  endfunction

  function automatic void fill_rand(input bit extremes);
    int unsigned sel;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        sel = $urandom_range(0, 3);
        if (extremes && sel == 0)      img[r][c] = -8'sd128;
        else if (extremes && sel == 1) img[r][c] = 8'sd127;
        else                           img[r][c] = DW'($urandom);
      end
  endfunction

  // Every valid window of the frame, row-major, top-left pixel first.
  function automatic void build_exp();
    win_t w;
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[(8 - (i * 3 + j)) * DW +: DW] = img[r - 2 + i][c - 2 + j];
        exp_q.push_back(w);
        exp_coord_q.push_back((r - 2) * 16 + (c - 2));
      end
  endfunction

  function automatic void clear_obs();
    cap_q.delete(); coord_q.delete(); low_q.delete();
    exp_q.delete(); exp_coord_q.delete();
    hold_err = 0; double_err = 0; fd_err = 0; ready_err = 0;
    fd_cnt = 0; done_total = 0; fd_done_idx = -1;
  endfunction

  task automatic send_pix(input logic signed [DW-1:0] v);
    int t;
    t = 0;
    pix_in = v;
    pix_valid = 1'b1;
    while (pix_ready !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) begin
      checks++; errors++;
      $display("FAIL send_pix_timeout: pix_ready=%b, required 1 within %0d cycles", pix_ready, TMO);
      pix_valid = 1'b0;
      return;
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic stream_frame(input int gapmax, input int npix);
    for (int k = 0; k < npix; k++) begin
      send_pix(img[k / W][k % W]);
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((pend || pix_ready !== 1'b1) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pend=%0d pix_ready=%b, required idle", pend, pix_ready);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({pix_ready, conv_start, frame_done, w_cur} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {pix_ready, conv_start, frame_done, w_cur});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_ready: got %b, required 0", pix_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after_idle: got %b, required 1", pix_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    win_t first_ref, last_ref;
    clear_obs();
    done_delay = 3; rand_delay = 0;
    fill_seq(1);
    build_exp();
    stream_frame(0, W * H);
    drain();
    first_ref = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    last_ref  = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_win_count: got %0d, required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_win[%0d]: got %h, required %h", i, cap_q[i], exp_q[i]);
      end
    end
    if (cap_q.size() == 4) begin
      checks++;
      if (cap_q[0] !== first_ref || cap_q[3] !== last_ref) begin
        errors++;
        $display("FAIL basic_first_last: got %h / %h, required %h / %h", cap_q[0], cap_q[3], first_ref, last_ref);
      end
    end
`ifdef CONV_WIN_COORD_EN
    for (int i = 0; i < coord_q.size() && i < exp_coord_q.size(); i++) begin
      checks++;
      if (coord_q[i] != exp_coord_q[i]) begin
        errors++;
        $display("FAIL basic_coord[%0d]: got %0h, required %0h", i, coord_q[i], exp_coord_q[i]);
      end
    end
`endif
    checks++;
    if (fd_cnt != 1 || fd_done_idx != 4 || fd_err != 0) begin
      errors++;
      $display("FAIL basic_frame_done: count %0d after done #%0d (orphans %0d), required 1 after done #4", fd_cnt, fd_done_idx, fd_err);
    end
  endtask

  task automatic test_backpressure();
    clear_obs();
    done_delay = 12; rand_delay = 0;
    fill_rand(0);
    build_exp();
    stream_frame(0, W * H);
    drain();
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_win_count: got %0d, required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_win[%0d]: got %h, required %h", i, cap_q[i], exp_q[i]);
      end
    end
    foreach (low_q[i]) begin
      checks++;
      if (low_q[i] != 13) begin
        errors++;
        $display("FAIL bp_ready_low[%0d]: got %0d cycles, required 13", i, low_q[i]);
      end
    end
    checks++;
    if (hold_err != 0 || ready_err != 0) begin
      errors++;
      $display("FAIL bp_hold: window changes %0d, late ready %0d, required 0/0", hold_err, ready_err);
    end
  endtask

  task automatic test_back_to_back();
    win_t f2_ref;
    clear_obs();
    done_delay = 2; rand_delay = 0;
    fill_seq(1);
    build_exp();
    stream_frame(0, W * H);
    fill_seq(101);
    build_exp();
    stream_frame(0, W * H);
    drain();
    f2_ref = {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111};
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_win_count: got %0d, required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_win[%0d]: got %h, required %h", i, cap_q[i], exp_q[i]);
      end
    end
    if (cap_q.size() > 4) begin
      checks++;
      if (cap_q[4] !== f2_ref) begin
        errors++;
        $display("FAIL b2b_frame2_first: got %h, required %h", cap_q[4], f2_ref);
      end
    end
    checks++;
    if (fd_cnt != 2) begin
      errors++;
      $display("FAIL b2b_frame_done: got %0d pulses, required 2", fd_cnt);
    end
  endtask

  task automatic test_clr();
    win_t held;
    clear_obs();
    done_delay = 12; rand_delay = 0;
    fill_seq(1);
    stream_frame(0, 2 * W + 3);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    held = (cap_q.size() > 0) ? cap_q[0] : '0;
    checks++;
    if (pix_ready !== 1'b1 || w_cur !== held || cap_q.size() != 1) begin
      errors++;
      $display("FAIL clr_abort: ready %b win %h starts %0d, required 1 / %h / 1", pix_ready, w_cur, cap_q.size(), held);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (fd_cnt != 0 || done_total != 0) begin
      errors++;
      $display("FAIL clr_stale_done: frame_done %0d conv_done %0d, required 0/0", fd_cnt, done_total);
    end
    done_delay = 3;
    fill_rand(0);
    build_exp();
    stream_frame(1, W * H);
    drain();
    checks++;
    if (cap_q.size() != 1 + exp_q.size()) begin
      errors++;
      $display("FAIL clr_win_count: got %0d, required %0d", cap_q.size(), 1 + exp_q.size());
    end
    for (int i = 0; i + 1 < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i + 1] !== exp_q[i]) begin
        errors++;
        $display("FAIL clr_win[%0d]: got %h, required %h", i, cap_q[i + 1], exp_q[i]);
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL clr_frame_done: got %0d pulses, required 1", fd_cnt);
    end
  endtask

  task automatic test_random();
    clear_obs();
    rand_delay = 1;
    for (int f = 0; f < 3; f++) begin
      fill_rand(1);
      build_exp();
      stream_frame(5, W * H);
    end
    drain();
    rand_delay = 0;
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_win_count: got %0d, required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_win[%0d]: got %h, required %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (double_err != 0 || hold_err != 0 || fd_err != 0 || ready_err != 0 || fd_cnt != 3) begin
      errors++;
      $display("FAIL rand_protocol: dbl %0d hold %0d orphan_fd %0d ready %0d fd %0d, required 0/0/0/0/3",
               double_err, hold_err, fd_err, ready_err, fd_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    clear_obs();
    done_delay = 12; rand_delay = 0;
    fill_seq(1);
    stream_frame(0, 2 * W + 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_ready, conv_start, frame_done, w_cur} !== '0) begin
      errors++;
      $display("FAIL wait_reset_outputs: got %h, required 0", {pix_ready, conv_start, frame_done, w_cur});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_reset_idle: got %b, required 0", pix_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_reset_ready: got %b, required 1", pix_ready);
    end
    @(negedge clk);
    clear_obs();
    done_delay = 4;
    fill_rand(1);
    build_exp();
    stream_frame(2, W * H);
    drain();
    checks++;
    if (cap_q.size() != exp_q.size() || fd_cnt != 1) begin
      errors++;
      $display("FAIL wait_reset_frame: windows %0d frame_done %0d, required %0d / 1", cap_q.size(), fd_cnt, exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wait_reset_win[%0d]: got %h, required %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_clr();
    test_random();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
